ad_tp_mc: RTL

Parametrised multi-channel ADC test-pattern generator. It is the successor to the single-channel ramp source in the `ad_top` path. Each programmed frame period it emits one frame of NCH sample words on a valid/ready stream, one word per channel. Pattern is ramp, constant, toggle or PRBS, with optional bursts and overrun detection. It sits in front of the AD channel packer as a drop-in replacement for live converter data.

---
 rtl/ad_tp_mc_if.sv | 14 +
 rtl/ad_tp_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ad_tp_mc_if.sv
// Sample stream between the test-pattern generator and the AD channel packer.
// A word transfers on any rising edge where tp_vld & tp_rdy; while tp_vld is high and tp_rdy low, tp_data/tp_ch/tp_last stay stable.
interface ad_tp_mc_if #(
    parameter int DW = 24
);
    logic [DW-1:0] tp_data;
    logic [3:0]    tp_ch;
    logic          tp_vld;
    logic          tp_last;
    logic          tp_rdy;

    modport master (output tp_data, output tp_ch, output tp_vld, output tp_last, input tp_rdy);
    modport slave  (input tp_data, input tp_ch, input tp_vld, input tp_last, output tp_rdy);
endinterface

// File: rtl/ad_tp_mc.sv
// Multi-channel ADC test-pattern generator: one frame of NCH words per programmed period,
// ramp / constant / toggle / PRBS patterns, bursts, overrun flag and live config reload.
module ad_tp_mc #(
    parameter int DW    = 24,
    parameter int NCH   = 4,
    parameter int STEPW = 8,
    parameter int PW    = 24
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             cfg_tp_en,
    input  logic [1:0]       cfg_tp_mode,
    input  logic [PW-1:0]    cfg_tp_period,
    input  logic [DW-1:0]    cfg_tp_base,
    input  logic [STEPW-1:0] cfg_tp_step,
    input  logic [STEPW-1:0] cfg_tp_ofs,
    input  logic [15:0]      cfg_tp_burst,
    ad_tp_mc_if.master       tp,
    output logic [15:0]      tp_frm_cnt,
    output logic             tp_ovf,
    output logic             tp_done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] M_RAMP   = 2'd0;
    localparam logic [1:0] M_TOGGLE = 2'd2;
    localparam logic [1:0] M_PRBS   = 2'd3;

    state_t state, state_nxt;

    logic [PW-1:0]    per_cnt, p_eff;
    logic [DW-1:0]    acc, word_raw, ofs_lat;
    logic [DW-1:0]    base_q;
    logic [1:0]       mode_q;
    logic [STEPW-1:0] step_q, ofs_q;
    logic [31:0]      lfsr, seed, lfsr_shift, start_lfsr;
    logic [3:0]       ch;
    logic [15:0]      frm_cnt_inc;
    logic             frm_idx, frm_inv, frm_prbs, pend;
    logic             tick, accept, last_word, chg, reload, enter;
    logic             start, ovf_set, done_set, cnt_inc;
    logic [DW-1:0]    start_acc, start_raw;
    logic             start_par, start_inv, start_prbs;

    // Datapath helpers; a pending reload (config changed mid-frame) applies at the next frame start.
    always_comb begin
        p_eff       = (cfg_tp_period == '0) ? PW'(1) : cfg_tp_period;
        tick        = (per_cnt >= p_eff - PW'(1));
        accept      = (state == S_SEND) && tp.tp_rdy;
        last_word   = (ch == 4'(NCH - 1));
        frm_cnt_inc = tp_frm_cnt + 16'd1;
        chg         = cfg_tp_en && ((cfg_tp_mode != mode_q) || (cfg_tp_base != base_q) ||
                                    (cfg_tp_step != step_q) || (cfg_tp_ofs != ofs_q));
        reload      = pend | chg;
        seed        = (32'(cfg_tp_base) == 32'h0) ? 32'h1 : 32'(cfg_tp_base);
        lfsr_shift  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        start_acc   = reload ? cfg_tp_base : acc;
        start_par   = reload ? 1'b0 : frm_idx;
        start_lfsr  = reload ? seed : (accept ? lfsr_shift : lfsr);
        start_raw   = (cfg_tp_mode == M_RAMP) ? start_acc : cfg_tp_base;
        start_inv   = (cfg_tp_mode == M_TOGGLE) && start_par;
        start_prbs  = (cfg_tp_mode == M_PRBS);
    end

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        start     = 1'b0;
        ovf_set   = 1'b0;
        done_set  = 1'b0;
        cnt_inc   = 1'b0;
        if (!cfg_tp_en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_WAIT;
                    enter     = 1'b1;
                end
                S_WAIT: begin
                    if (tick) begin
                        state_nxt = S_SEND;
                        start     = 1'b1;
                    end
                end
                S_SEND: begin
                    if (accept && last_word) begin
                        cnt_inc = 1'b1;
                        if ((cfg_tp_burst != 16'd0) && (frm_cnt_inc == cfg_tp_burst)) begin
                            state_nxt = S_DONE;
                            done_set  = 1'b1;
                        end else if (tick) begin
                            start = 1'b1;
                        end else begin
                            state_nxt = S_WAIT;
                        end
                    end else if (tick) begin
                        ovf_set = 1'b1;
                    end
                end
                default: state_nxt = S_DONE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            per_cnt    <= '0;
            acc        <= '0;
            word_raw   <= '0;
            ofs_lat    <= '0;
            base_q     <= '0;
            mode_q     <= '0;
            step_q     <= '0;
            ofs_q      <= '0;
            lfsr       <= 32'h1;
            ch         <= '0;
            frm_idx    <= 1'b0;
            frm_inv    <= 1'b0;
            frm_prbs   <= 1'b0;
            pend       <= 1'b0;
            tp_frm_cnt <= '0;
            tp_ovf     <= 1'b0;
            tp_done    <= 1'b0;
        end else begin
            mode_q <= cfg_tp_mode;
            base_q <= cfg_tp_base;
            step_q <= cfg_tp_step;
            ofs_q  <= cfg_tp_ofs;

            if (enter) begin
                per_cnt    <= '0;
                acc        <= cfg_tp_base;
                frm_idx    <= 1'b0;
                lfsr       <= seed;
                pend       <= 1'b0;
                tp_frm_cnt <= '0;
                tp_ovf     <= 1'b0;
                tp_done    <= 1'b0;
            end else begin
                if (cfg_tp_en && (state != S_IDLE))
                    per_cnt <= tick ? '0 : per_cnt + PW'(1);
                pend <= start ? 1'b0 : (pend | chg);
                if (cnt_inc)  tp_frm_cnt <= frm_cnt_inc;
                if (ovf_set)  tp_ovf     <= 1'b1;
                if (done_set) tp_done    <= 1'b1;

                if (start) begin
                    acc      <= start_acc + DW'(cfg_tp_step);
                    frm_idx  <= ~start_par;
                    lfsr     <= start_lfsr;
                    ch       <= '0;
                    word_raw <= start_raw;
                    ofs_lat  <= DW'(cfg_tp_ofs);
                    frm_inv  <= start_inv;
                    frm_prbs <= start_prbs;
                end else if (accept) begin
                    lfsr <= lfsr_shift;
                    if (!last_word) begin
                        ch       <= ch + 4'd1;
                        word_raw <= word_raw + ofs_lat;
                    end
                end
            end
        end
    end

    assign tp.tp_vld   = (state == S_SEND);
    assign tp.tp_ch    = ch;
    assign tp.tp_last  = (state == S_SEND) && last_word;
    assign tp.tp_data  = frm_prbs ? lfsr[DW-1:0] : (frm_inv ? ~word_raw : word_raw);
    assign dbg_state   = state;

endmodule
